// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding and
// instruction-source constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        BIOS   = 2'd0,
        SWITCH = 2'd1,
        USER   = 2'd2
    } fetch_state_t;

    localparam logic SRC_BIOS = 1'b0;
    localparam logic SRC_MAIN = 1'b1;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC from BIOS ROM into main memory, with one-cycle
// memory latency. Optional forced BIOS exit under macro FETCH_BIOS_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           TIMEOUT    = 1023
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branchTaken,
    input  logic [DATA_WIDTH-1:0] branchTarget,
    input  logic                  changeSource,
    input  logic [DATA_WIDTH-1:0] biosInst,
    input  logic [DATA_WIDTH-1:0] memInst,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instOut,
    output logic                  instValid,
    output logic                  source,
    output logic                  biosTimeout
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  src_q, src_d;
    logic                  valid_q, valid_d;
    logic                  hold_now, stalled_q;
    logic                  prev_src_q;
    logic [DATA_WIDTH-1:0] held_q;
    logic                  timeout_hit;

`ifdef FETCH_BIOS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt_q;
    logic          to_q;

    assign timeout_hit = (state_q == BIOS) && (tcnt_q == CW'(TIMEOUT - 1));
    assign biosTimeout = to_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            if (state_q == BIOS)
                tcnt_q <= tcnt_q + 1'b1;
            if (timeout_hit && !changeSource)
                to_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign biosTimeout    = 1'b0;
`endif

    // Next-state, next-PC and fetch-validity decision; priority is
    // switch > branch > stall > increment.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        src_d    = src_q;
        valid_d  = 1'b1;
        hold_now = 1'b0;
        unique case (state_q)
            BIOS: begin
                if (changeSource || timeout_hit) begin
                    state_d = SWITCH;
                    pc_d    = RESET_PC;
                    src_d   = SRC_MAIN;
                end else if (branchTaken) begin
                    pc_d    = branchTarget;
                    valid_d = 1'b0;
                end else if (stall) begin
                    hold_now = 1'b1;
                end else begin
                    pc_d = pc_q + DATA_WIDTH'(1);
                end
            end
            // PC holds here so the RESET_PC fetch issued in USER is not lost.
            SWITCH: begin
                state_d = USER;
                valid_d = 1'b0;
            end
            USER: begin
                if (branchTaken) begin
                    pc_d    = branchTarget;
                    valid_d = 1'b0;
                end else if (stall) begin
                    hold_now = 1'b1;
                end else begin
                    pc_d = pc_q + DATA_WIDTH'(1);
                end
            end
            default: state_d = BIOS;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            state_q <= BIOS;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            src_q <= SRC_BIOS;
        end else begin
            pc_q  <= pc_d;
            src_q <= src_d;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            stalled_q  <= 1'b0;
            prev_src_q <= SRC_BIOS;
            held_q     <= '0;
        end else begin
            stalled_q  <= hold_now;
            prev_src_q <= src_q;
            held_q     <= instOut;
            if (!hold_now)
                valid_q <= valid_d;
        end
    end

    // While stalled the memories re-read the held PC, so replay the last word.
    assign instOut   = stalled_q ? held_q : ((prev_src_q == SRC_MAIN) ? memInst : biosInst);
    assign instValid = valid_q;
    assign pc        = pc_q;
    assign source    = src_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table plus directed reset/switch/timeout sequences.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        changeSource = 1'b0;
    logic [31:0] biosInst = '0;
    logic [31:0] memInst = '0;
    logic [31:0] pc;
    logic [31:0] instOut;
    logic        instValid;
    logic        source;
    logic        biosTimeout;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0),
        .TIMEOUT   (8)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .changeSource(changeSource),
        .biosInst    (biosInst),
        .memInst     (memInst),
        .pc          (pc),
        .instOut     (instOut),
        .instValid   (instValid),
        .source      (source),
        .biosTimeout (biosTimeout)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] bios_w(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] main_w(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Registered ROM/RAM models: data for the address presented at the edge.
    always @(posedge clock) begin
        biosInst <= bios_w(pc);
        memInst  <= main_w(pc);
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        cs;
        logic [31:0] epc;
        logic        esrc;
        logic        evalid;
        logic        chk;
        logic [31:0] einst;
    } vec_t;

    vec_t tbl[36];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic c,
                                input logic [31:0] p, input logic sr, input logic v,
                                input logic k, input logic [31:0] i);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.cs = c;
        r.epc = p; r.esrc = sr; r.evalid = v; r.chk = k; r.einst = i;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; changeSource = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        rst = 1'b1;
    endtask

    initial begin
        // Entry i: inputs applied in cycle i, outputs expected in cycle i+1.
        for (int i = 0; i < 15; i++)
            tbl[i] = mk(0, 0, 0, 0, 32'(i + 1), 0, 1, 1, bios_w(32'(i)));
        tbl[15] = mk(0, 0, 0, 1, 32'h0, 1, 1, 1, bios_w(32'd15));
        tbl[16] = mk(0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        tbl[17] = mk(0, 0, 0, 0, 32'h1, 1, 1, 1, main_w(32'h0));
        tbl[18] = mk(0, 0, 0, 0, 32'h2, 1, 1, 1, main_w(32'h1));
        tbl[19] = mk(0, 0, 0, 0, 32'h3, 1, 1, 1, main_w(32'h2));
        tbl[20] = mk(0, 0, 0, 0, 32'h4, 1, 1, 1, main_w(32'h3));
        tbl[21] = mk(0, 0, 0, 0, 32'h5, 1, 1, 1, main_w(32'h4));
        tbl[22] = mk(1, 0, 0, 0, 32'h5, 1, 1, 1, main_w(32'h4));
        tbl[23] = mk(1, 0, 0, 0, 32'h5, 1, 1, 1, main_w(32'h4));
        tbl[24] = mk(1, 0, 0, 0, 32'h5, 1, 1, 1, main_w(32'h4));
        tbl[25] = mk(0, 0, 0, 0, 32'h6, 1, 1, 1, main_w(32'h5));
        tbl[26] = mk(0, 0, 0, 0, 32'h7, 1, 1, 1, main_w(32'h6));
        tbl[27] = mk(0, 1, 32'h40, 0, 32'h40, 1, 0, 0, 32'h0);
        tbl[28] = mk(0, 0, 0, 0, 32'h41, 1, 1, 1, main_w(32'h40));
        tbl[29] = mk(0, 0, 0, 1, 32'h42, 1, 1, 1, main_w(32'h41));
        tbl[30] = mk(0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1, 0, 0, 32'h0);
        tbl[31] = mk(0, 0, 0, 0, 32'h0, 1, 1, 1, main_w(32'hFFFF_FFFF));
        tbl[32] = mk(1, 1, 32'h100, 0, 32'h100, 1, 0, 0, 32'h0);
        tbl[33] = mk(0, 0, 0, 0, 32'h101, 1, 1, 1, main_w(32'h100));
        tbl[34] = mk(1, 0, 0, 0, 32'h101, 1, 1, 1, main_w(32'h100));
        tbl[35] = mk(0, 0, 0, 0, 32'h102, 1, 1, 1, main_w(32'h101));

        #2;
        check("reset pc", pc, 32'h0);
        check("reset source", 32'(source), 32'h0);
        check("reset instValid", 32'(instValid), 32'h0);
        check("reset biosTimeout", 32'(biosTimeout), 32'h0);

`ifndef FETCH_BIOS_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 36; i++) begin
            stall = tbl[i].stall; branchTaken = tbl[i].br;
            branchTarget = tbl[i].tgt; changeSource = tbl[i].cs;
            tick();
            check($sformatf("vec%0d pc", i), pc, tbl[i].epc);
            check($sformatf("vec%0d source", i), 32'(source), 32'(tbl[i].esrc));
            check($sformatf("vec%0d instValid", i), 32'(instValid), 32'(tbl[i].evalid));
            if (tbl[i].chk)
                check($sformatf("vec%0d instOut", i), instOut, tbl[i].einst);
        end
        clear_inputs();

        // Branch and changeSource together in BIOS at pc=15: switch wins.
        do_reset();
        repeat (15) tick();
        check("prio pc15", pc, 32'd15);
        changeSource = 1'b1; branchTaken = 1'b1; branchTarget = 32'h77;
        tick();
        clear_inputs();
        check("prio pc", pc, 32'h0);
        check("prio source", 32'(source), 32'h1);
        tick();
        check("prio bubble", 32'(instValid), 32'h0);

        // Without the timeout feature BIOS never leaves on its own.
        do_reset();
        repeat (12) tick();
        check("noto pc", pc, 32'd12);
        check("noto source", 32'(source), 32'h0);
        check("noto biosTimeout", 32'(biosTimeout), 32'h0);
`else
        // Forced exit after 8 BIOS cycles with TIMEOUT=8.
        do_reset();
        repeat (7) tick();
        check("to pre pc", pc, 32'd7);
        check("to pre source", 32'(source), 32'h0);
        check("to pre flag", 32'(biosTimeout), 32'h0);
        tick();
        check("to pc", pc, 32'h0);
        check("to source", 32'(source), 32'h1);
        check("to flag", 32'(biosTimeout), 32'h1);
        repeat (5) tick();
        check("to sticky", 32'(biosTimeout), 32'h1);
        #3 rst = 1'b0;
        #1 check("to cleared", 32'(biosTimeout), 32'h0);
`endif

        // Asynchronous reset mid-USER at pc=0x20.
        do_reset();
        repeat (3) tick();
        changeSource = 1'b1;
        tick();
        changeSource = 1'b0;
        tick();
        repeat (32) tick();
        check("user pc20", pc, 32'h20);
        check("user source", 32'(source), 32'h1);
        #3 rst = 1'b0;
        #1;
        check("async pc", pc, 32'h0);
        check("async source", 32'(source), 32'h0);
        check("async instValid", 32'(instValid), 32'h0);
        @(negedge clock);
        rst = 1'b1;
        tick();
        check("post pc", pc, 32'h1);
        check("post instValid", 32'(instValid), 32'h1);
        check("post instOut", instOut, bios_w(32'h0));

        // Reset during the SWITCH cycle.
        do_reset();
        repeat (3) tick();
        changeSource = 1'b1;
        tick();
        changeSource = 1'b0;
        check("sw source", 32'(source), 32'h1);
        #3 rst = 1'b0;
        #1 check("sw rst source", 32'(source), 32'h0);
        @(negedge clock);
        rst = 1'b1;
        tick();
        check("sw post pc", pc, 32'h1);
        check("sw post source", 32'(source), 32'h0);
        check("sw post instValid", 32'(instValid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
